// File: rtl/store_buffer.sv
// Write-back store buffer: queues processor stores, drains them to a handshaked
// byte memory in the background, and forwards loads from pending stores.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no memory request outstanding; choose miss read or drain
// RD    | load-miss read outstanding; processor stalled until mem_ack
// WR    | head entry being written to memory; popped on mem_ack
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_we,
  input  logic                       cpu_re,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [1:0]        state;

  logic              push, pop, ld, hit, ld_miss, rd_done;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  idx;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign push    = cpu_we & ~full;
  assign pop     = (state == S_WR) & mem_ack;
  assign ld      = cpu_re & ~cpu_we;
  assign ld_miss = ld & ~hit;
  assign rd_done = (state == S_RD) & mem_ack;

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (buf_addr[idx] == cpu_addr)) begin
        hit      = 1'b1;
        fwd_data = buf_data[idx];
      end
    end
  end

  always_comb begin
    cpu_rdata = '0;
    cpu_stall = cpu_we & full;
    if (ld) begin
      if (hit) begin
        cpu_rdata = fwd_data;
      end else if (rd_done) begin
        cpu_rdata = mem_rdata;
      end else begin
        cpu_stall = 1'b1;
      end
    end
  end

  // Entry storage needs no reset: validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail] <= cpu_addr;
      buf_data[tail] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);

      case (state)
        S_IDLE: begin
          if (ld_miss) begin
            state    <= S_RD;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cpu_addr;
          end else if (!empty) begin
            state     <= S_WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= buf_addr[head];
            mem_wdata <= buf_data[head];
          end
        end
        S_RD, S_WR: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a vector table for the store/drain flow
// plus hand sequences for forwarding, miss reads, read priority and reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we, cpu_re;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        empty, full;

  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [15:0] a; logic [7:0] d;
  } tx_t;
  tx_t log_q[$];

  // Completed memory transactions, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && mem_req && mem_ack)
      log_q.push_back('{mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)});
  end

  always @(posedge clk) begin
    if (reset) assert (!(cpu_we && cpu_re)) else $error("illegal simultaneous store and load");
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic we, re; logic [15:0] addr; logic [7:0] wd; logic ack; logic [7:0] mrd;
    logic stall; logic [7:0] rdata; logic [2:0] cnt; logic full, empty, req, mwe;
    logic [15:0] maddr; logic [7:0] mwd;
  } row_t;

  row_t rows[21];

  function automatic row_t mk(logic we, logic re, logic [15:0] addr, logic [7:0] wd,
                              logic ack, logic [7:0] mrd, logic stall, logic [7:0] rdata,
                              logic [2:0] cnt, logic fl, logic em, logic req, logic mwe,
                              logic [15:0] maddr, logic [7:0] mwd);
    row_t r;
    r.we = we; r.re = re; r.addr = addr; r.wd = wd; r.ack = ack; r.mrd = mrd;
    r.stall = stall; r.rdata = rdata; r.cnt = cnt; r.full = fl; r.empty = em;
    r.req = req; r.mwe = mwe; r.maddr = maddr; r.mwd = mwd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_log(input int i, input logic we, input logic [15:0] a, input logic [7:0] d);
    if (i < log_q.size()) begin
      chk($sformatf("log%0d", i), {log_q[i].we, log_q[i].a, log_q[i].d}, {we, a, d});
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL log%0d: got no transaction expected %0h", i, {we, a, d});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic we, input logic re, input logic [15:0] a, input logic [7:0] wd,
                     input logic ack, input logic [7:0] mrd);
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = wd; mem_ack = ack; mem_rdata = mrd;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    cyc();
    drv(0, 0, 16'h0, 8'h0, 1, 8'h0);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (count == 3'd0 && !mem_req) done = 1'b1;
      else cyc();
    end
    chk("drain_done", {63'd0, done}, 64'd1);
    cyc();
    mem_ack = 1'b0;
  endtask

  initial begin
    //             we re addr      wd     ack mrd   stall rd  cnt fl em req mwe maddr     mwd
    rows[0]  = mk(1, 0, 16'h0010, 8'hA5, 1, 8'h0, 0, 8'h0, 0, 0, 1, 0, 0, 16'h0000, 8'h00);
    rows[1]  = mk(1, 0, 16'h0011, 8'h3C, 1, 8'h0, 0, 8'h0, 1, 0, 0, 0, 0, 16'h0000, 8'h00);
    rows[2]  = mk(0, 0, 16'h0000, 8'h00, 1, 8'h0, 0, 8'h0, 2, 0, 0, 1, 1, 16'h0010, 8'hA5);
    rows[3]  = mk(0, 0, 16'h0000, 8'h00, 1, 8'h0, 0, 8'h0, 1, 0, 0, 0, 0, 16'h0000, 8'h00);
    rows[4]  = mk(0, 0, 16'h0000, 8'h00, 1, 8'h0, 0, 8'h0, 1, 0, 0, 1, 1, 16'h0011, 8'h3C);
    rows[5]  = mk(0, 0, 16'h0000, 8'h00, 0, 8'h0, 0, 8'h0, 0, 0, 1, 0, 0, 16'h0000, 8'h00);
    rows[6]  = mk(1, 0, 16'h0020, 8'h40, 0, 8'h0, 0, 8'h0, 0, 0, 1, 0, 0, 16'h0000, 8'h00);
    rows[7]  = mk(1, 0, 16'h0021, 8'h41, 0, 8'h0, 0, 8'h0, 1, 0, 0, 0, 0, 16'h0000, 8'h00);
    rows[8]  = mk(1, 0, 16'h0022, 8'h42, 0, 8'h0, 0, 8'h0, 2, 0, 0, 1, 1, 16'h0020, 8'h40);
    rows[9]  = mk(1, 0, 16'h0023, 8'h43, 0, 8'h0, 0, 8'h0, 3, 0, 0, 1, 1, 16'h0020, 8'h40);
    rows[10] = mk(1, 0, 16'h0024, 8'h44, 0, 8'h0, 1, 8'h0, 4, 1, 0, 1, 1, 16'h0020, 8'h40);
    rows[11] = mk(1, 0, 16'h0024, 8'h44, 1, 8'h0, 1, 8'h0, 4, 1, 0, 1, 1, 16'h0020, 8'h40);
    rows[12] = mk(1, 0, 16'h0024, 8'h44, 0, 8'h0, 0, 8'h0, 3, 0, 0, 0, 0, 16'h0000, 8'h00);
    rows[13] = mk(0, 0, 16'h0000, 8'h00, 1, 8'h0, 0, 8'h0, 4, 1, 0, 1, 1, 16'h0021, 8'h41);
    rows[14] = mk(0, 0, 16'h0000, 8'h00, 1, 8'h0, 0, 8'h0, 3, 0, 0, 0, 0, 16'h0000, 8'h00);
    rows[15] = mk(0, 0, 16'h0000, 8'h00, 1, 8'h0, 0, 8'h0, 3, 0, 0, 1, 1, 16'h0022, 8'h42);
    rows[16] = mk(0, 0, 16'h0000, 8'h00, 1, 8'h0, 0, 8'h0, 2, 0, 0, 0, 0, 16'h0000, 8'h00);
    rows[17] = mk(0, 0, 16'h0000, 8'h00, 1, 8'h0, 0, 8'h0, 2, 0, 0, 1, 1, 16'h0023, 8'h43);
    rows[18] = mk(0, 0, 16'h0000, 8'h00, 1, 8'h0, 0, 8'h0, 1, 0, 0, 0, 0, 16'h0000, 8'h00);
    rows[19] = mk(0, 0, 16'h0000, 8'h00, 1, 8'h0, 0, 8'h0, 1, 0, 0, 1, 1, 16'h0024, 8'h44);
    rows[20] = mk(0, 0, 16'h0000, 8'h00, 0, 8'h0, 0, 8'h0, 0, 0, 1, 0, 0, 16'h0000, 8'h00);

    reset = 1'b0;
    drv(0, 0, 16'h0, 8'h0, 0, 8'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        {mem_req, mem_we, mem_addr, mem_wdata, count, empty, full, cpu_stall, cpu_rdata},
        {1'b0, 1'b0, 16'h0, 8'h0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h0});
    cyc();
    reset = 1'b1;

    // Store, drain in order, fill to full, stall and release.
    log_q.delete();
    for (int i = 0; i < 21; i++) begin
      logic [39:0] act, exp;
      cyc();
      drv(rows[i].we, rows[i].re, rows[i].addr, rows[i].wd, rows[i].ack, rows[i].mrd);
      @(negedge clk);
      act = {cpu_stall, cpu_rdata, count, full, empty, mem_req,
             (mem_req ? {mem_we, mem_addr, mem_wdata} : 25'd0)};
      exp = {rows[i].stall, rows[i].rdata, rows[i].cnt, rows[i].full, rows[i].empty, rows[i].req,
             (rows[i].req ? {rows[i].mwe, rows[i].maddr, rows[i].mwd} : 25'd0)};
      chk($sformatf("row%0d", i), {24'd0, act}, {24'd0, exp});
    end
    #2;
    chk("log_size_fifo", log_q.size(), 7);
    chk_log(0, 1, 16'h0010, 8'hA5);
    chk_log(1, 1, 16'h0011, 8'h3C);
    chk_log(2, 1, 16'h0020, 8'h40);
    chk_log(3, 1, 16'h0021, 8'h41);
    chk_log(4, 1, 16'h0022, 8'h42);
    chk_log(5, 1, 16'h0023, 8'h43);
    chk_log(6, 1, 16'h0024, 8'h44);

    // Forwarding from the youngest of two stores to the same address.
    log_q.delete();
    cyc(); drv(1, 0, 16'h0030, 8'h11, 0, 8'h0); @(negedge clk);
    cyc(); drv(1, 0, 16'h0030, 8'h22, 0, 8'h0); @(negedge clk);
    cyc(); drv(0, 1, 16'h0030, 8'h00, 0, 8'h0); @(negedge clk);
    chk("fwd_youngest", {cpu_stall, cpu_rdata}, {1'b0, 8'h22});
    chk("fwd_mem_busy_wr", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 16'h0030});
    cyc(); drv(0, 0, 16'h0000, 8'h00, 0, 8'h0); @(negedge clk);
    chk("fwd_after", {cpu_rdata, count, mem_we}, {8'h00, 3'd2, 1'b1});
    drain();
    #2;
    chk("log_size_fwd", log_q.size(), 2);
    chk_log(0, 1, 16'h0030, 8'h11);
    chk_log(1, 1, 16'h0030, 8'h22);

    // Miss on empty buffer with three memory wait cycles.
    log_q.delete();
    cyc(); drv(0, 1, 16'h0040, 8'h00, 0, 8'h00); @(negedge clk);
    chk("miss_decide", {cpu_stall, cpu_rdata, mem_req}, {1'b1, 8'h00, 1'b0});
    for (int w = 0; w < 3; w++) begin
      cyc(); @(negedge clk);
      chk($sformatf("miss_wait%0d", w), {cpu_stall, mem_req, mem_we, mem_addr},
          {1'b1, 1'b1, 1'b0, 16'h0040});
    end
    cyc(); drv(0, 1, 16'h0040, 8'h00, 1, 8'h7E); @(negedge clk);
    chk("miss_ack", {cpu_stall, cpu_rdata, mem_req, mem_we}, {1'b0, 8'h7E, 1'b1, 1'b0});
    cyc(); drv(0, 0, 16'h0000, 8'h00, 0, 8'h00); @(negedge clk);
    chk("miss_done", {cpu_stall, cpu_rdata, mem_req}, {1'b0, 8'h00, 1'b0});
    #2;
    chk("log_size_miss", log_q.size(), 1);
    chk_log(0, 0, 16'h0040, 8'h00);

    // Miss read takes priority over draining two pending stores.
    log_q.delete();
    cyc(); drv(1, 0, 16'h0060, 8'h01, 0, 8'h0); @(negedge clk);
    cyc(); drv(1, 0, 16'h0061, 8'h02, 0, 8'h0); @(negedge clk);
    cyc(); drv(1, 0, 16'h0062, 8'h03, 1, 8'h0); @(negedge clk);
    chk("prio_first_wr", {count, mem_req, mem_we, mem_addr}, {3'd2, 1'b1, 1'b1, 16'h0060});
    cyc(); drv(0, 1, 16'h0050, 8'h00, 0, 8'h0); @(negedge clk);
    chk("prio_decide", {cpu_stall, count, mem_req}, {1'b1, 3'd2, 1'b0});
    cyc(); drv(0, 1, 16'h0050, 8'h00, 1, 8'h99); @(negedge clk);
    chk("prio_read", {cpu_stall, cpu_rdata, mem_req, mem_we, mem_addr},
        {1'b0, 8'h99, 1'b1, 1'b0, 16'h0050});
    drain();
    #2;
    chk("log_size_prio", log_q.size(), 4);
    chk_log(0, 1, 16'h0060, 8'h01);
    chk_log(1, 0, 16'h0050, 8'h00);
    chk_log(2, 1, 16'h0061, 8'h02);
    chk_log(3, 1, 16'h0062, 8'h03);

    // Asynchronous reset in the middle of a write with three entries held.
    log_q.delete();
    cyc(); drv(1, 0, 16'h0070, 8'h07, 0, 8'h0); @(negedge clk);
    cyc(); drv(1, 0, 16'h0071, 8'h08, 0, 8'h0); @(negedge clk);
    cyc(); drv(1, 0, 16'h0072, 8'h09, 0, 8'h0); @(negedge clk);
    cyc(); drv(0, 0, 16'h0000, 8'h00, 0, 8'h0); @(negedge clk);
    chk("pre_reset", {count, mem_req, mem_we, mem_addr}, {3'd3, 1'b1, 1'b1, 16'h0070});
    #1 reset = 1'b0;
    #1;
    chk("async_reset", {mem_req, count, empty, full, cpu_stall},
        {1'b0, 3'd0, 1'b1, 1'b0, 1'b0});
    cyc(); cyc();
    reset = 1'b1;
    mem_ack = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    chk("post_reset_idle", {count, mem_req}, {3'd0, 1'b0});
    #2;
    chk("post_reset_no_writes", log_q.size(), 0);
    mem_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-back store buffer between the processor's data port (memwrite / dataadr / writedata / readdata) and a slow, handshaked byte-wide data memory.
- Processor stores are queued and drained in the background, so stores do not stall unless the buffer is full.
- Loads are forwarded from pending stores when the address matches. Otherwise they are fetched from memory while the processor is stalled.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2
- ADDR_W, 16, data address width
- DATA_W, 8, data word width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- cpu_we  input  1  processor store strobe (memwrite)
- cpu_re  input  1  processor load strobe
- cpu_addr  input  ADDR_W  processor data address (dataadr)
- cpu_wdata  input  DATA_W  store data (writedata)
- cpu_rdata  output  DATA_W  load data (readdata)
- cpu_stall  output  1  processor must hold its current access
- mem_req  output  1  memory request valid
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid when mem_ack
- mem_ack  input  1  memory completes the current request this cycle
- count  output  $clog2(DEPTH+1)  occupied entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH

Behaviour:
- Reset (reset = 0, asynchronous):
  - All entries are invalidated and head and tail pointers go to 0.
  - State goes to IDLE.
  - Output values: mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, count = 0, empty = 1, full = 0, cpu_stall = 0, cpu_rdata = 0.
  - Reset during an outstanding request drops mem_req immediately. Pending stores are discarded.
- Storage: circular FIFO of {addr, data}. Pointers wrap modulo DEPTH.
- Store path:
  - If cpu_we = 1 and full = 0: the entry is written at the tail on the clock edge and count increments. cpu_stall = 0.
  - If cpu_we = 1 and full = 1: cpu_stall = 1 and nothing is enqueued.
  - full is the registered value. A pop in the same cycle does not unblock the store until the next cycle.
- Load path:
  - cpu_we has priority. A cycle with cpu_we = 1 and cpu_re = 1 is illegal; the bench asserts it never occurs. If it does occur, the load is ignored.
  - If cpu_re = 1, all valid entries are searched combinationally for addr == cpu_addr.
  - Hit: the youngest matching entry's data drives cpu_rdata in the same cycle. cpu_stall = 0.
  - Miss: cpu_stall = 1 until the memory read completes.
  - When cpu_re = 0, cpu_rdata = 0.
- FSM states: IDLE, RD, WR.
  - IDLE, cpu_re miss: go to RD. Reads have priority over draining.
  - IDLE, otherwise, empty = 0: go to WR.
  - RD: mem_req = 1, mem_we = 0, mem_addr = cpu_addr. On mem_ack: cpu_rdata = mem_rdata and cpu_stall = 0 in that same cycle; go to IDLE.
  - WR: mem_req = 1, mem_we = 1, mem_addr and mem_wdata driven from the head entry. On mem_ack: pop head, count decrements, go to IDLE.
  - mem_req, mem_we, mem_addr and mem_wdata are registered. They are stable from assertion until the mem_ack cycle.
  - mem_req is deasserted the cycle after mem_ack. There is at least one idle cycle between requests.
- Request timing: a request starts the cycle after the IDLE decision. Minimum latency is 2 cycles for a miss load with a 0-wait memory (request cycle plus ack in the same cycle).
- Simultaneous push and pop: count is unchanged and pointers both advance.
- Stores arriving during WR are enqueued at the tail. The head entry being drained is never modified.
- A store to the same address as the entry being drained is enqueued as a separate entry. There is no coalescing.
- A miss load never needs ordering against pending stores, since no pending store matches its address.

Test Plan:
- Reset, then stores to 0x0010 = 0xA5 and 0x0011 = 0x3C with mem_ack tied 1 → count goes 1, 2, then drains. Memory sees write 0x0010/0xA5 then write 0x0011/0x3C in order; cpu_stall stays 0.
- Hold mem_ack = 0. Issue 5 consecutive stores 0x20..0x24 → cpu_stall = 1 on the 5th with full = 1 and count = 4. Release ack for one cycle → the 5th store enqueues the following cycle and stall drops.
- Stores 0x0030 = 0x11 then 0x0030 = 0x22 while memory is stalled, then load 0x0030 → cpu_rdata = 0x22 in the same cycle, cpu_stall = 0, no memory read issued.
- Load 0x0040 on an empty buffer with memory returning 0x7E after 3 wait cycles → cpu_stall high until the ack cycle, cpu_rdata = 0x7E in the ack cycle, mem_we = 0 throughout.
- Buffer holding 2 stores, load miss to 0x0050 while IDLE → the read is issued before the remaining drains; stores drain afterwards in FIFO order.
- Assert reset mid-WR with count = 3 → mem_req = 0 and count = 0 immediately. No further memory writes after release.
